// File: rtl/cb_down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a one-cycle TC pulse.
// Define CB_DOWN_TIMER_TMR_EN to triplicate all state with majority voting.
module cb_down_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [Width-1:0] DIN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             AUTO,
    output logic [Width-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             TC
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        state_t           st;
        logic [Width-1:0] rld;
        logic [Width-1:0] cnt;
        logic             tc;
    } timer_s;

    // Next state of the whole timer from the current (voted) state and this cycle's inputs.
    function automatic timer_s step(
        input timer_s           cur,
        input logic             ce,
        input logic             load,
        input logic [Width-1:0] din,
        input logic             start,
        input logic             abort,
        input logic             auto_rld
    );
        timer_s           nxt;
        logic [Width-1:0] v;
        nxt    = cur;
        nxt.tc = 1'b0;
        v      = load ? din : cur.rld;
        if (load) begin
            nxt.rld = din;
        end
        if (abort) begin
            nxt.st  = ST_IDLE;
            nxt.cnt = '0;
        end else if (start) begin
            if (v != '0) begin
                nxt.cnt = v;
                nxt.st  = ST_RUN;
            end else begin
                // A zero-length timer expires on the start edge itself.
                nxt.cnt = '0;
                nxt.st  = ST_DONE;
                nxt.tc  = 1'b1;
            end
        end else if (cur.st == ST_RUN) begin
            if (ce) begin
                if (cur.cnt > Width'(1)) begin
                    nxt.cnt = cur.cnt - Width'(1);
                end else begin
                    nxt.tc = 1'b1;
                    if (auto_rld && (cur.rld != '0)) begin
                        nxt.cnt = cur.rld;
                    end else begin
                        nxt.cnt = '0;
                        nxt.st  = ST_DONE;
                    end
                end
            end
        end else if (load) begin
            nxt.cnt = din;
        end
        return nxt;
    endfunction

    timer_s tv;

`ifdef CB_DOWN_TIMER_TMR_EN
    (* syn_preserve = 1 *) timer_s tr [3];
    (* syn_keep = 1 *)     timer_s voted;

    // Bitwise majority; a single upset copy is rewritten from the vote next edge.
    assign voted = (tr[0] & tr[1]) | (tr[0] & tr[2]) | (tr[1] & tr[2]);
    assign tv    = voted;

    for (genvar i = 0; i < 3; i++) begin : g_copy
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                tr[i] <= '0;
            end else begin
                tr[i] <= step(voted, CE, LOAD, DIN, START, ABORT, AUTO);
            end
        end
    end
`else
    timer_s tr;

    assign tv = tr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tr <= '0;
        end else begin
            tr <= step(tr, CE, LOAD, DIN, START, ABORT, AUTO);
        end
    end
`endif

    assign Q    = tv.cnt;
    assign BUSY = (tv.st == ST_RUN);
    assign DONE = (tv.st == ST_DONE);
    assign TC   = tv.tc;

endmodule

// File: tb/tb_cb_down_timer.sv
// Randomized and directed bench for cb_down_timer against a behavioural timer model.
module tb_cb_down_timer;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         CE = 1'b0;
    logic         LOAD = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         START = 1'b0;
    logic         ABORT = 1'b0;
    logic         AUTO = 1'b0;
    logic [W-1:0] Q;
    logic         BUSY;
    logic         DONE;
    logic         TC;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 counting, 2 expired.
    int m_mode = 0;
    int m_rld  = 0;
    int m_cnt  = 0;
    int m_tc   = 0;
    int tc_seen;

    cb_down_timer #(.Width(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CE   (CE),
        .LOAD (LOAD),
        .DIN  (DIN),
        .START(START),
        .ABORT(ABORT),
        .AUTO (AUTO),
        .Q    (Q),
        .BUSY (BUSY),
        .DONE (DONE),
        .TC   (TC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_rld  = 0;
        m_cnt  = 0;
        m_tc   = 0;
    endtask

    // One clock edge of the timer's documented rules, on plain integers.
    task automatic model_edge();
        int new_rld;
        int v;
        new_rld = LOAD ? int'(DIN) : m_rld;
        v       = new_rld;
        m_tc    = 0;
        if (ABORT) begin
            m_mode = 0;
            m_cnt  = 0;
        end else if (START) begin
            m_cnt  = v;
            m_mode = (v == 0) ? 2 : 1;
            m_tc   = (v == 0) ? 1 : 0;
        end else if (m_mode == 1) begin
            if (CE) begin
                if (m_cnt > 1) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_tc = 1;
                    if (AUTO && m_rld > 0) m_cnt = m_rld;
                    else begin
                        m_cnt  = 0;
                        m_mode = 2;
                    end
                end
            end
        end else if (LOAD) begin
            m_cnt = int'(DIN);
        end
        m_rld = new_rld;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".Q"}, 32'(Q), 32'(m_cnt));
        check({tag, ".BUSY"}, 32'(BUSY), 32'(m_mode == 1));
        check({tag, ".DONE"}, 32'(DONE), 32'(m_mode == 2));
        check({tag, ".TC"}, 32'(TC), 32'(m_tc));
    endtask

    task automatic cyc(input string tag, input logic ce, input logic load, input logic [W-1:0] din,
                       input logic start, input logic abort, input logic auto_rld);
        CE    = ce;
        LOAD  = load;
        DIN   = din;
        START = start;
        ABORT = abort;
        AUTO  = auto_rld;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all(tag);
        if (TC) tc_seen++;
    endtask

    initial begin
        #12;
        compare_all("reset");
        @(negedge CLK);
        RST = 1'b0;

        // One-shot from 5.
        cyc("ld5", 0, 1, 8'd5, 0, 0, 0);
        cyc("st5", 0, 0, 8'd0, 1, 0, 0);
        check("st5_q", 32'(Q), 32'd5);
        tc_seen = 0;
        for (int i = 0; i < 6; i++) cyc("run5", 1, 0, 8'd0, 0, 0, 0);
        check("one_shot_tc_count", 32'(tc_seen), 32'd1);
        check("one_shot_done", 32'(DONE), 32'd1);

        // Auto-reload period 3 over 10 CE cycles.
        cyc("ld3", 0, 1, 8'd3, 1, 0, 1);
        tc_seen = 0;
        for (int i = 0; i < 10; i++) cyc("auto3", 1, 0, 8'd0, 0, 0, 1);
        check("auto_tc_count", 32'(tc_seen), 32'd3);
        check("auto_busy", 32'(BUSY), 32'd1);

        // CE toggling with reload 4: TC on the 4th enabled edge.
        cyc("ld4", 0, 1, 8'd4, 1, 0, 0);
        tc_seen = 0;
        for (int i = 0; i < 8; i++) cyc("ce_tog", (i % 2) == 0, 0, 8'd0, 0, 0, 0);
        check("ce_tog_tc_count", 32'(tc_seen), 32'd1);

        // Zero-length timer.
        cyc("abort0", 0, 0, 8'd0, 0, 1, 0);
        cyc("zero", 0, 1, 8'd0, 1, 0, 0);
        check("zero_tc", 32'(TC), 32'd1);
        check("zero_busy", 32'(BUSY), 32'd0);

        // Abort at Q=2 with CE high.
        cyc("ld5b", 0, 1, 8'd5, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("pre_abort", 1, 0, 8'd0, 0, 0, 0);
        check("pre_abort_q", 32'(Q), 32'd2);
        cyc("abort", 1, 0, 8'd0, 0, 1, 0);

        // Asynchronous reset mid-count, sampled before any further edge.
        cyc("st_rst", 1, 0, 8'd0, 1, 0, 0);
        cyc("run_rst", 1, 0, 8'd0, 0, 0, 0);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge CLK);
        RST = 1'b0;

        // Reload value changed mid-run takes effect at next reload.
        cyc("ld6", 0, 1, 8'd6, 1, 0, 1);
        cyc("run6", 1, 0, 8'd0, 0, 0, 1);
        cyc("run6", 1, 0, 8'd0, 0, 0, 1);
        cyc("ld2_run", 0, 1, 8'd2, 0, 0, 1);
        check("ld2_q_untouched", 32'(Q), 32'd4);
        for (int i = 0; i < 4; i++) cyc("run4to1", 1, 0, 8'd0, 0, 0, 1);
        check("reload_to_2", 32'(Q), 32'd2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, d,
                $urandom_range(0, 14) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_down_timer.md
Name: cb_down_timer

Overview:
Loadable binary down-counter/timer: the counting-down complement to the team's up-counting event counters.
- Software or a control FSM loads a reload value and starts the timer.
- The timer decrements on each CE-qualified clock and signals terminal count with a one-cycle TC pulse.
- Supports one-shot and auto-reload modes.
- Used for VME timeouts, readout-window timing and periodic strobes in the DMB control logic.

Parameters:
Width, 8, bit width of reload value and count.

Ports:
CLK  input  1  system clock; all state on rising edge.
RST  input  1  reset, asynchronous, active-high.
CE  input  1  count enable; decrement only when high in RUN.
LOAD  input  1  load reload register from DIN.
DIN  input  Width  reload value.
START  input  1  begin countdown from reload value.
ABORT  input  1  cancel countdown, return to IDLE.
AUTO  input  1  1 = auto-reload at terminal count, 0 = one-shot.
Q  output  Width  current count.
BUSY  output  1  high while in RUN.
DONE  output  1  level, high in DONE state.
TC  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Registers: RLD (reload value), CNT, state (IDLE, RUN, DONE), TC flop.
- Reset (async, RST high): state=IDLE, RLD=0, CNT=0; Q=0, BUSY=0, DONE=0, TC=0.
- Priority per edge: ABORT > START > CE/terminal logic; LOAD is evaluated in parallel.
- TC is 0 in every cycle unless set by a terminal event.
- Outputs: Q=CNT; BUSY=(state==RUN); DONE=(state==DONE). TC comes directly from a flop, with no combinational path from inputs.
- LOAD:
  - In any state: RLD<=DIN.
  - In IDLE/DONE it also sets CNT<=DIN.
  - In RUN, CNT is untouched; the new RLD takes effect at the next reload or START.
- START in IDLE or DONE:
  - The effective value V is DIN if LOAD is high in the same cycle, else RLD.
  - V!=0: CNT<=V, state<=RUN.
  - V==0: CNT<=0, state<=DONE, TC<=1 (zero-length timer ends immediately).
- START in RUN: restart; CNT<=V, stay RUN, no TC.
- RUN, CE high:
  - CNT>1: CNT<=CNT-1.
  - CNT==1: TC<=1, then:
    - AUTO=1: CNT<=RLD (if RLD==0, state<=DONE, CNT<=0).
    - AUTO=0: CNT<=0, state<=DONE.
- RUN, CE low: hold everything.
- Latency:
  - START at edge k gives BUSY=1 and Q=V after edge k.
  - With CE held high, TC is high in the cycle after the edge at which Q goes 1->0 (or reloads). That is V CE-cycles after START.
- ABORT (any state): state<=IDLE, CNT<=0, TC<=0. RLD is retained; a simultaneous LOAD still updates RLD.
- DONE state:
  - Stays until START or ABORT.
  - CE is ignored.
  - LOAD updates RLD and CNT, state unchanged.
- AUTO is sampled only at the terminal-count edge.
- Auto-reload period: exactly RLD CE-cycles between TC pulses, with no dead cycle.
- No wrap-around: CNT never decrements below 0.
- RST mid-count aborts immediately and asynchronously; no TC is generated.

Optional Feature:
CB_DOWN_TIMER_TMR_EN
- Defined:
  - RLD, CNT, state and TC are triplicated with syn_preserve.
  - Each copy's next-state is computed from the majority-voted values, and outputs are driven from voted values (syn_keep on voted nets).
  - A single-copy upset is corrected on the next clock edge.
- Undefined: single registers.
- Port list and cycle behaviour are identical in both builds.

Test Plan:
- Reset then LOAD DIN=5, START, CE=1 continuous -> Q 5,4,3,2,1,0; TC pulses once in the cycle after Q becomes 0; DONE=1, BUSY=0.
- RLD=3, AUTO=1, CE=1 for 10 cycles -> TC pulses every 3 cycles (Q 3,2,1,3,2,1,...), BUSY stays 1.
- RLD=4, CE toggling 1/0 -> Q decrements only on CE-high edges; TC after the 4th CE-high edge.
- LOAD DIN=0 with START -> DONE=1 and TC=1 the next cycle, BUSY never asserts.
- RUN at Q=2, ABORT with CE=1 -> Q=0, IDLE, no TC; separately, RST asserted mid-count -> all outputs 0 immediately.
- RUN with RLD=6, LOAD DIN=2 at Q=4, AUTO=1 -> counts 4..1, TC, reloads to 2.
- With CB_DOWN_TIMER_TMR_EN, force-flip one CNT copy bit -> Q unaffected and the copy is corrected next edge.
